bus_fabric: RTL

Parametrised memory-mapped bus fabric for the 65C02 system, replacing the fixed address decode, read-data mux and IRQ OR-ing of the top level. Registers the CPU's unregistered address, decodes it against NUM_SLAVES base/mask windows, and drives per-slave chip selects and the read-data mux. Adds three things the fixed decode lacks: per-slave wait states on the CPU RDY line, a maskable edge/level IRQ controller, and an unmapped-access error counter, all behind a 4-byte control window.

---
 rtl/bus_fabric.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/bus_fabric.sv
// bus_fabric: registered address capture, base/mask slave decode, per-slave
// wait states on cpu_rdy, maskable edge/level IRQ controller and an
// unmapped-access error counter behind a 4-byte control window.
//
// Handshake: cpu_rdy acts as "ready" for the CPU address phase. On every
// posedge clk with cpu_rdy=1 the CPU's address/we/data are accepted, and the
// previously captured access completes in that same cycle. cpu_rdy=0 stalls
// the CPU and freezes the captured access until its wait count expires.
module bus_fabric #(
   parameter int                         NUM_SLAVES    = 4,
   parameter logic [16*NUM_SLAVES-1:0]   BASE          = {16'h8000, 16'h6000, 16'h5000, 16'h0000},
   parameter logic [16*NUM_SLAVES-1:0]   MASK          = {16'h8000, 16'hFFF0, 16'hFFF0, 16'hC000},
   parameter logic [4*NUM_SLAVES-1:0]    WAIT          = {4'd0, 4'd1, 4'd2, 4'd0},
   parameter logic [15:0]                CTRL_BASE     = 16'h5F00,
   parameter logic [7:0]                 UNMAPPED_DATA = 8'hFF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [15:0]               cpu_addr,
   input  logic                      cpu_we,
   input  logic [7:0]                cpu_do,
   output logic [7:0]                cpu_di,
   output logic                      cpu_rdy,
   output logic                      cpu_irq,
   output logic [15:0]               slv_addr,
   output logic [NUM_SLAVES-1:0]     slv_cs,
   output logic                      slv_we,
   output logic [7:0]                slv_wdata,
   input  logic [8*NUM_SLAVES-1:0]   slv_rdata,
   input  logic [7:0]                irq_in,
   output logic [3:0]                dbg_wait_cnt
);

   logic       we_q;
   logic [3:0] cnt, cnt_next, cap_wait;
   logic       cap_hit;
   logic       ctrl_hit, sel_hit, unmapped, reg_wr;
   logic [7:0] sel_rdata, ctrl_rdata;
   logic [7:0] irq_mask, irq_mode, edge_lat, irq_q, pending, clr_bits, err_count;

   // Wait count of the access being presented by the CPU (ctrl/unmapped = 0)
   always_comb begin
      cap_wait = '0;
      cap_hit  = 1'b0;
      if (cpu_addr[15:2] != CTRL_BASE[15:2]) begin
         for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!cap_hit && ((cpu_addr & MASK[16*i +: 16]) == BASE[16*i +: 16])) begin
               cap_hit  = 1'b1;
               cap_wait = WAIT[4*i +: 4];
            end
         end
      end
   end

   assign ctrl_hit = (slv_addr[15:2] == CTRL_BASE[15:2]);

   // Decode of the captured address: lowest matching slave wins, ctrl window overrides
   always_comb begin
      slv_cs    = '0;
      sel_hit   = 1'b0;
      sel_rdata = UNMAPPED_DATA;
      if (!ctrl_hit) begin
         for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!sel_hit && ((slv_addr & MASK[16*i +: 16]) == BASE[16*i +: 16])) begin
               sel_hit   = 1'b1;
               slv_cs[i] = 1'b1;
               sel_rdata = slv_rdata[8*i +: 8];
            end
         end
      end
   end

   assign unmapped = !ctrl_hit && !sel_hit;

   // Wait counter state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt <= '0;
      else       cnt <= cnt_next;
   end

   // Wait counter next state: reload at capture, otherwise count down
   always_comb begin
      cnt_next = (cnt == 4'd0) ? cap_wait : cnt - 4'd1;
   end

   // Wait FSM outputs: ready when idle, one write strobe in the completing cycle
   always_comb begin
      cpu_rdy      = (cnt == 4'd0);
      slv_we       = we_q & cpu_rdy & sel_hit;
      dbg_wait_cnt = cnt;
   end

   // Capture the CPU address phase whenever the fabric is ready
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slv_addr  <= '0;
         we_q      <= 1'b0;
         slv_wdata <= '0;
      end else if (cpu_rdy) begin
         slv_addr  <= cpu_addr;
         we_q      <= cpu_we;
         slv_wdata <= cpu_do;
      end
   end

   assign reg_wr   = we_q & cpu_rdy & ctrl_hit;
   assign clr_bits = (reg_wr && slv_addr[1:0] == 2'd0) ? slv_wdata : 8'h00;
   assign pending  = (irq_mode & edge_lat) | (~irq_mode & irq_in);

   // Control register read mux
   always_comb begin
      case (slv_addr[1:0])
         2'd0:    ctrl_rdata = pending & irq_mask;
         2'd1:    ctrl_rdata = irq_mask;
         2'd2:    ctrl_rdata = irq_mode;
         default: ctrl_rdata = err_count;
      endcase
   end

   assign cpu_di = ctrl_hit ? ctrl_rdata : sel_rdata;

   // IRQ controller: mask/mode registers, edge latches (set beats clear), output register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_mask <= '0;
         irq_mode <= '0;
         edge_lat <= '0;
         irq_q    <= '0;
         cpu_irq  <= 1'b0;
      end else begin
         if (reg_wr && slv_addr[1:0] == 2'd1) irq_mask <= slv_wdata;
         if (reg_wr && slv_addr[1:0] == 2'd2) irq_mode <= slv_wdata;
         // Level-mode bits hold no latched state
         edge_lat <= irq_mode & ((edge_lat & ~clr_bits) | (irq_in & ~irq_q));
         irq_q    <= irq_in;
         cpu_irq  <= |(pending & irq_mask);
      end
   end

   // Saturating count of completed unmapped accesses; write-clear wins
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_count <= '0;
      end else if (reg_wr && slv_addr[1:0] == 2'd3) begin
         err_count <= '0;
      end else if (cpu_rdy && unmapped && err_count != 8'hFF) begin
         err_count <= err_count + 8'd1;
      end
   end

endmodule
